// File: rtl/scfifo_nibble_packer_pkg.sv
// Shared definitions for the SCFIFO nibble packer.
// Holds the default geometry, a constant log2 helper, and the encoding of
// the per-cycle assembly-buffer action that the top-level control decodes.
package scfifo_nibble_packer_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_N      = 2;

  // Ceiling log2 for constant width derivation; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) begin
        result = 32'(i + 1);
      end
    end
    return result;
  endfunction

  // What the assembly buffer does in a given cycle.
  typedef enum logic [2:0] {
    ACT_IDLE,        // nothing lands, nothing leaves
    ACT_LAND,        // fifo_data appended, word not yet handed off
    ACT_LAND_LOAD,   // fifo_data completes the word and goes straight to the slot
    ACT_STALL_LOAD,  // previously completed word finally moves to the slot
    ACT_FLUSH_LOAD,  // partial word moves to the slot, flush completes
    ACT_FLUSH_CLR    // flush with nothing buffered, just retire it
  } asm_act_e;

endpackage

// File: rtl/scfifo_nibble_packer_out_slot.sv
// One-entry output register for the nibble packer.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   load                load load_data/load_cnt this cycle (only while slot_free)
//   load_data, load_cnt packed word and its valid entry count
//   out_ready           consumer accepts when out_valid & out_ready
//   out_data, out_cnt   registered word presented downstream
//   out_valid           registered valid
//   slot_free           slot can take a new word at the coming edge
module packer_out_slot #(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_valid,
  output logic             slot_free
);

  // Empty, or emptying at this edge because the consumer accepts.
  assign slot_free = ~out_valid | out_ready;

  // Load wins over accept so back-to-back words keep out_valid high;
  // with neither, data and count hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_cnt   <= load_cnt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/scfifo_nibble_packer.sv
// Drains an SCFIFO and packs N consecutive DATA_W-bit entries into one
// OUT_W-bit word (first entry in the LSBs), with a flush that emits a
// partial word.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   fifo_empty        SCFIFO empty flag
//   fifo_rd           SCFIFO read strobe (combinational)
//   fifo_data         SCFIFO read data, valid the cycle after a sampled read
//   out_data/out_cnt  packed word and its number of valid entries
//   out_valid         out_data/out_cnt valid
//   out_ready         consumer accept
//   flush             single-cycle request to emit any partial word
//   busy              entries held, read in flight, output or flush pending
module scfifo_nibble_packer
  import scfifo_nibble_packer_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned N      = DEF_N,
  localparam int unsigned OUT_W  = DATA_W * N,
  localparam int unsigned CNT_W  = clog2(N + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic              busy
);

  localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W:0]   N_OCC  = (CNT_W + 1)'(N);

  logic [OUT_W-1:0] asm_q, asm_d, asm_ins;
  logic [CNT_W-1:0] asm_cnt_q, asm_cnt_d;
  logic             rd_pend_q;
  logic             flush_req_q, flush_req_d;
  logic [CNT_W:0]   occ;
  logic             slot_free;
  logic             load;
  logic [OUT_W-1:0] load_data;
  logic [CNT_W-1:0] load_cnt;
  asm_act_e         act;

  // Entries owned by the packer, counting the one still in flight.
  assign occ = {1'b0, asm_cnt_q} + (CNT_W + 1)'(rd_pend_q);

  // Issue a read only if its entry will have somewhere to land; at
  // occ == N that room comes from the full word leaving this cycle.
  assign fifo_rd = reset_n & ~fifo_empty & ~flush_req_q &
                   ((occ < N_OCC) | ((occ == N_OCC) & slot_free));

  assign busy = (asm_cnt_q != '0) | rd_pend_q | out_valid | flush_req_q;

  // Buffer with the landing entry inserted at the next free position.
  always_comb begin
    asm_ins = asm_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (asm_cnt_q == CNT_W'(i)) begin
        asm_ins[i*DATA_W +: DATA_W] = fifo_data;
      end
    end
  end

  // Decide this cycle's buffer action. A landing entry always takes
  // priority; a flush is only serviced once no read is in flight.
  always_comb begin
    act = ACT_IDLE;
    if (rd_pend_q) begin
      if ((asm_cnt_q == N_LAST) && slot_free) begin
        act = ACT_LAND_LOAD;
      end else begin
        act = ACT_LAND;
      end
    end else if (asm_cnt_q == N_CNT) begin
      if (slot_free) begin
        act = ACT_STALL_LOAD;
      end
    end else if (flush_req_q) begin
      if (asm_cnt_q == '0) begin
        act = ACT_FLUSH_CLR;
      end else if (slot_free) begin
        act = ACT_FLUSH_LOAD;
      end
    end
  end

  // Next-state and slot-load values for the chosen action.
  always_comb begin
    asm_d       = asm_q;
    asm_cnt_d   = asm_cnt_q;
    flush_req_d = flush_req_q | flush;
    load        = 1'b0;
    load_data   = asm_q;
    load_cnt    = asm_cnt_q;
    unique case (act)
      ACT_LAND: begin
        asm_d     = asm_ins;
        asm_cnt_d = asm_cnt_q + CNT_W'(1);
      end
      ACT_LAND_LOAD: begin
        load      = 1'b1;
        load_data = asm_ins;
        load_cnt  = N_CNT;
        asm_d     = '0;
        asm_cnt_d = '0;
      end
      ACT_STALL_LOAD: begin
        load      = 1'b1;
        load_cnt  = N_CNT;
        asm_d     = '0;
        asm_cnt_d = '0;
      end
      ACT_FLUSH_LOAD: begin
        // Unused high entries are already zero because the buffer is
        // cleared every time it empties.
        load        = 1'b1;
        asm_d       = '0;
        asm_cnt_d   = '0;
        flush_req_d = 1'b0;
      end
      ACT_FLUSH_CLR: begin
        asm_d       = '0;
        asm_cnt_d   = '0;
        flush_req_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q       <= '0;
      asm_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      flush_req_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      asm_cnt_q   <= asm_cnt_d;
      rd_pend_q   <= fifo_rd;
      flush_req_q <= flush_req_d;
    end
  end

  packer_out_slot #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_out_slot (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_scfifo_nibble_packer.sv
// Self-checking bench for scfifo_nibble_packer (DATA_W=4, N=2).
// A queue models the SCFIFO; popped entries feed a packing model whose
// expected words go to a scoreboard checked by an independent monitor.
module tb_scfifo_nibble_packer;

  localparam int NW = 2;

  typedef struct {
    int data;
    int cnt;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [3:0] fifo_data;
  logic [7:0] out_data;
  logic [1:0] out_cnt;
  logic       out_valid;
  logic       out_ready;
  logic       flush;
  logic       busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   fq[$];
  int   pend[$];
  exp_t expq[$];
  logic s_rd, s_valid, s_flush;
  int   reads_since = 0;
  int   since_flush = 1000;

  logic       hold = 1'b0;
  logic [7:0] hold_data;
  logic [1:0] hold_cnt;

  scfifo_nibble_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .out_data   (out_data),
    .out_cnt    (out_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pack the pending entries, first entry in the low nibble.
  function automatic void push_word();
    exp_t e;
    e.data = 0;
    foreach (pend[i]) e.data = e.data + (pend[i] << (4 * i));
    e.cnt = pend.size();
    expq.push_back(e);
    pend.delete();
  endfunction

  task automatic push(input int v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample strobes at negedge, then advance the FIFO/packing model.
  task automatic step();
    int v;
    @(negedge clk);
    s_rd    = fifo_rd;
    s_valid = out_valid;
    s_flush = flush;
    @(posedge clk);
    #1;
    since_flush++;
    if (s_rd && reset_n && fq.size() > 0) begin
      v = fq.pop_front();
      fifo_data = 4'(v);
      pend.push_back(v);
      reads_since++;
      if (pend.size() == NW) push_word();
    end
    if (s_flush && reset_n) begin
      if (pend.size() > 0) push_word();
      reads_since = 0;
      since_flush = 0;
    end
    flush = 1'b0;
    fifo_empty = (fq.size() == 0);
  endtask

  // Monitor: accepted words against the scoreboard, hold stability, read gating.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (fifo_empty) chk("rd_when_empty", 32'(fifo_rd), 0);
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
        chk("hold_cnt", 32'(out_cnt), 32'(hold_cnt));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("out_data", 32'(out_data), e.data);
          chk("out_cnt", 32'(out_cnt), e.cnt);
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_cnt  = out_cnt;
    end
  end

  initial begin
    int first_rd, last_rd, first_v, last_v, nrd, nv;

    // Reset with hostile inputs.
    reset_n = 1'b0; fifo_empty = 1'b0; flush = 1'b1; out_ready = 1'b1; fifo_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_fifo_rd", 32'(fifo_rd), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    @(posedge clk); #1;
    flush = 1'b0; fifo_empty = 1'b1; reset_n = 1'b1;

    // Stream 4,A,3,C with ready held high.
    push(4); push(10); push(3); push(12);
    first_rd = -1; last_rd = -1; first_v = -1; last_v = -1; nrd = 0; nv = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (s_rd) begin nrd++; if (first_rd < 0) first_rd = c; last_rd = c; end
      if (s_valid) begin nv++; if (first_v < 0) first_v = c; last_v = c; end
    end
    chk("stream_reads", 32'(nrd), 4);
    chk("stream_rd_span", 32'(last_rd - first_rd), 3);
    chk("stream_latency", 32'(first_v - first_rd), 3);
    chk("stream_words", 32'(nv), 2);
    chk("stream_word_spacing", 32'(last_v - first_v), NW);

    // Backpressure: 1..6 with ready low takes exactly four reads.
    out_ready = 1'b0;
    for (int v = 1; v <= 6; v++) push(v);
    nrd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_rd) nrd++;
    end
    chk("bp_reads", 32'(nrd), 4);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data", 32'(out_data), 32'h21);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();

    // Flush a single buffered entry, then flush with nothing buffered.
    push(5);
    for (int c = 0; c < 5; c++) step();
    flush = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("flush_busy_done", 32'(busy), 0);
    flush = 1'b1;
    step();
    chk("flush_empty_busy", 32'(busy), 1);
    chk("flush_empty_valid", 32'(out_valid), 0);
    step();
    chk("flush_empty_idle", 32'(busy), 0);
    chk("flush_empty_novalid", 32'(out_valid), 0);

    // Empty source for 50 cycles.
    nrd = 0; nv = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (s_rd) nrd++;
      if (s_valid) nv++;
    end
    chk("empty_reads", 32'(nrd), 0);
    chk("empty_valids", 32'(nv), 0);

    // Mid-operation reset: slot full, one entry buffered, more data waiting.
    out_ready = 1'b0;
    push(1); push(2); push(3);
    for (int c = 0; c < 8; c++) step();
    chk("mr_pre_valid", 32'(out_valid), 1);
    chk("mr_pre_busy", 32'(busy), 1);
    push(9);
    reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_fifo_rd", 32'(fifo_rd), 0);
    fq.delete(); pend.delete(); expq.delete();
    fifo_empty = 1'b1;
    step(); step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    push(7); push(8);
    for (int c = 0; c < 10; c++) step();
    chk("mr_drained", 32'(expq.size()), 0);

    // Randomized traffic, backpressure and flushes.
    for (int c = 0; c < 2000; c++) begin
      step();
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 4 && fq.size() < 8) push(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 29) == 0 && (reads_since > 0 || since_flush > 60)) flush = 1'b1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) step();
    flush = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("final_words_left", 32'(expq.size()), 0);
    chk("final_fifo_left", 32'(fq.size()), 0);
    chk("final_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
